trap_ctrl: RTL

Trap and return sequencer that sits directly upstream of the CSR register file. It watches the execute stage for synchronous exceptions, enabled interrupts and xRET instructions, and picks one event by fixed priority. It then drives a single-cycle `exception_pending` / `m_cause` / `pc_exc` / `x_ret` pulse into the CSR file and holds a pipeline flush while the front end redirects to `epc`.

---
 rtl/trap_ctrl_pkg.sv | 44 ++++
 rtl/trap_ctrl_prio_enc.sv | 63 ++++++
 rtl/trap_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared types for the trap sequencer: privilege modes, trap/interrupt
// cause codes and the sequencer state encoding.
package mode;
  typedef enum logic [1:0] {
    MODE_U = 2'd0,
    MODE_S = 2'd1,
    MODE_H = 2'd2,
    MODE_M = 2'd3
  } mode_t;
endpackage

package exception;
  localparam int unsigned CODE_W = 5;

  // Synchronous exception codes
  localparam logic [CODE_W-1:0] I_ADDR_MISALIGNED = 5'd0;
  localparam logic [CODE_W-1:0] I_ILLEGAL         = 5'd2;
  localparam logic [CODE_W-1:0] EBREAK            = 5'd3;
  localparam logic [CODE_W-1:0] L_ADDR_MISALIGNED = 5'd4;
  localparam logic [CODE_W-1:0] S_ADDR_MISALIGNED = 5'd6;
  localparam logic [CODE_W-1:0] ECALL_U           = 5'd8;

  // Interrupt codes
  localparam logic [CODE_W-1:0] IRQ_M_EXT   = 5'd11;
  localparam logic [CODE_W-1:0] IRQ_M_TIMER = 5'd7;
  localparam logic [CODE_W-1:0] IRQ_S_EXT   = 5'd9;
  localparam logic [CODE_W-1:0] IRQ_S_TIMER = 5'd5;

  // Bit positions inside exc_vec
  localparam int unsigned EXC_I_ADDR  = 0;
  localparam int unsigned EXC_ILLEGAL = 1;
  localparam int unsigned EXC_EBREAK  = 2;
  localparam int unsigned EXC_ECALL   = 3;
  localparam int unsigned EXC_L_MIS   = 4;
  localparam int unsigned EXC_S_MIS   = 5;
endpackage

package trap;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAP  = 2'd1,
    DRAIN = 2'd2
  } trap_state_t;
endpackage

// File: rtl/trap_ctrl_prio_enc.sv
// Fixed-priority event selector: interrupts, then exceptions, then xRET.
// ret_sel = {mret, sret, uret}; only one bit is ever set.
module trap_prio_enc
  import exception::*;
  import mode::*;
(
  input  logic              mei,
  input  logic              mti,
  input  logic              sei,
  input  logic              sti,
  input  logic [5:0]        exc_vec,
  input  logic              mret,
  input  logic              sret,
  input  logic              uret,
  input  mode_t             current_mode,
  output logic              hit,
  output logic              is_irq,
  output logic [CODE_W-1:0] code,
  output logic [2:0]        ret_sel
);

  // Priority chain; xRET leaves code at 0 so the cause reads as zero
  always_comb begin
    hit     = 1'b1;
    is_irq  = 1'b0;
    code    = '0;
    ret_sel = '0;
    if (mei) begin
      is_irq = 1'b1;
      code   = IRQ_M_EXT;
    end else if (mti) begin
      is_irq = 1'b1;
      code   = IRQ_M_TIMER;
    end else if (sei) begin
      is_irq = 1'b1;
      code   = IRQ_S_EXT;
    end else if (sti) begin
      is_irq = 1'b1;
      code   = IRQ_S_TIMER;
    end else if (exc_vec[EXC_I_ADDR]) begin
      code = I_ADDR_MISALIGNED;
    end else if (exc_vec[EXC_ILLEGAL]) begin
      code = I_ILLEGAL;
    end else if (exc_vec[EXC_EBREAK]) begin
      code = EBREAK;
    end else if (exc_vec[EXC_ECALL]) begin
      code = ECALL_U + CODE_W'(current_mode);
    end else if (exc_vec[EXC_L_MIS]) begin
      code = L_ADDR_MISALIGNED;
    end else if (exc_vec[EXC_S_MIS]) begin
      code = S_ADDR_MISALIGNED;
    end else if (mret) begin
      ret_sel = 3'b100;
    end else if (sret) begin
      ret_sel = 3'b010;
    end else if (uret) begin
      ret_sel = 3'b001;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap and return sequencer feeding the CSR file.
// Optional macro TRAP_IRQ_SYNC_EN: two-flop synchronizers on m_interrupt
// and s_interrupt (timer inputs are always used directly).
module trap_ctrl
  import exception::*;
  import mode::*;
  import trap::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [5:0]      exc_vec,
  input  logic            mret_i,
  input  logic            sret_i,
  input  logic            uret_i,
  input  mode_t           current_mode,
  input  logic            m_interrupt,
  input  logic            s_interrupt,
  input  logic            m_timer,
  input  logic            s_timer,
  input  logic            m_eie,
  input  logic            m_tie,
  input  logic            s_eie,
  input  logic            s_tie,
  output logic            exception_pending,
  output logic [XLEN-1:0] m_cause,
  output logic [XLEN-1:0] pc_exc,
  output logic            m_ret,
  output logic            s_ret,
  output logic            u_ret,
  output logic            flush,
  output logic            busy
);

  localparam int unsigned CNT_W = 4;

  trap_state_t       state, state_next;
  logic [CNT_W-1:0]  drain_cnt;
  logic [2:0]        ret_q;
  logic              m_ext, s_ext;
  logic              hit, is_irq;
  logic [CODE_W-1:0] code;
  logic [2:0]        ret_sel;
  logic              accept;

`ifdef TRAP_IRQ_SYNC_EN
  logic [1:0] m_sync, s_sync;

  // Two-flop synchronizers for the asynchronous external interrupt lines
  always_ff @(posedge clk) begin
    if (rst) begin
      m_sync <= '0;
      s_sync <= '0;
    end else begin
      m_sync <= {m_sync[0], m_interrupt};
      s_sync <= {s_sync[0], s_interrupt};
    end
  end

  assign m_ext = m_sync[1];
  assign s_ext = s_sync[1];
`else
  assign m_ext = m_interrupt;
  assign s_ext = s_interrupt;
`endif

  trap_prio_enc u_prio (
    .mei          (m_ext & m_eie),
    .mti          (m_timer & m_tie),
    .sei          (s_ext & s_eie),
    .sti          (s_timer & s_tie),
    .exc_vec      (exc_vec),
    .mret         (mret_i),
    .sret         (sret_i),
    .uret         (uret_i),
    .current_mode (current_mode),
    .hit          (hit),
    .is_irq       (is_irq),
    .code         (code),
    .ret_sel      (ret_sel)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and strobe decode
  always_comb begin
    state_next        = state;
    accept            = 1'b0;
    exception_pending = 1'b0;
    flush             = 1'b0;
    busy              = (state != IDLE);
    unique case (state)
      IDLE: begin
        accept = ex_valid && !stall && hit;
        if (accept) state_next = TRAP;
      end
      TRAP: begin
        exception_pending = 1'b1;
        flush             = 1'b1;
        state_next        = DRAIN;
      end
      DRAIN: begin
        flush = 1'b1;
        if (drain_cnt == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    m_ret = exception_pending & ret_q[2];
    s_ret = exception_pending & ret_q[1];
    u_ret = exception_pending & ret_q[0];
  end

  // Capture winner on acceptance; values hold until the next accepted event
  always_ff @(posedge clk) begin
    if (rst) begin
      m_cause <= '0;
      pc_exc  <= '0;
      ret_q   <= '0;
    end else if (accept) begin
      m_cause <= {is_irq, (XLEN-1)'(code)};
      pc_exc  <= ex_pc;
      ret_q   <= ret_sel;
    end
  end

  // Drain counter: loaded while leaving TRAP so DRAIN lasts FLUSH_CYCLES
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if (state == TRAP) begin
      drain_cnt <= CNT_W'(FLUSH_CYCLES - 1);
    end else if (state == DRAIN && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - 1'b1;
    end
  end

endmodule
